frogger_round_ctrl: RTL and testbench

- Top-level game sequencer for the Frogger playfield.
- Owns game phase, level counter and lives. Decides when cars move, when the frog is re-spawned, and when the 7-segment and LED displays update.
- Sits between the frog controller and car instances (which consume its enables and level) and the collision/goal detection (which it consumes).
- Replaces the ad-hoc wiring of level and lives that runs directly between those blocks.

---
 rtl/frogger_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_frogger_round_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/frogger_round_ctrl.sv
// Frogger round sequencer: game phase, level and lives; drives car enable, frog respawn and displays.
// Optional bonus life on every fifth level is enabled with `define FROGGER_BONUS_LIFE_EN.
module frogger_round_ctrl #(
  parameter int START_LIVES    = 3,
  parameter int MAX_LEVEL      = 99,
  parameter int GOAL_ROW       = 0,
  parameter int DEATH_FRAMES   = 60,
  parameter int LEVELUP_FRAMES = 30,
  parameter int OVER_FRAMES    = 180
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Game_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collided,
  input  logic [4:0] i_Frog_Y,
  output logic [2:0] o_State,
  output logic [6:0] o_Level,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Lives_LED,
  output logic       o_Frog_Reset,
  output logic       o_Cars_En,
  output logic       o_Flash
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam logic [1:0] START_LIVES_C = 2'(START_LIVES);
  localparam logic [6:0] MAX_LEVEL_C   = 7'(MAX_LEVEL);
  localparam logic [4:0] GOAL_ROW_C    = 5'(GOAL_ROW);
  localparam logic [7:0] DEATH_CNT     = 8'(DEATH_FRAMES);
  localparam logic [7:0] LEVELUP_CNT   = 8'(LEVELUP_FRAMES);
  localparam logic [7:0] OVER_CNT      = 8'(OVER_FRAMES);

  function automatic logic [2:0] lives_therm(input logic [1:0] n);
    case (n)
      2'd0:    lives_therm = 3'b000;
      2'd1:    lives_therm = 3'b001;
      2'd2:    lives_therm = 3'b011;
      default: lives_therm = 3'b111;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [6:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] lives_led_q;
  logic [7:0] cnt_q, cnt_d;
  logic       frog_reset_q, frog_reset_d;
  logic       flash_q, flash_d;
  logic       start_hist_q;
  logic       start_edge_s;

  assign start_edge_s = i_Game_Start & ~start_hist_q;

  // Next-state, level/lives update and frame counter.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    frog_reset_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge_s) begin
          state_d      = S_PLAY;
          level_d      = 7'd0;
          lives_d      = START_LIVES_C;
          frog_reset_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (i_Collided) begin
          state_d = S_DYING;
          lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
        end else if (i_Frog_Y == GOAL_ROW_C) begin
          state_d = S_LEVEL_UP;
          level_d = (level_q >= MAX_LEVEL_C) ? MAX_LEVEL_C : (level_q + 7'd1);
`ifdef FROGGER_BONUS_LIFE_EN
          if ((level_d != 7'd0) && ((level_d % 7'd5) == 7'd0) && (lives_q != 2'd3)) begin
            lives_d = lives_q + 2'd1;
          end else begin
            lives_d = lives_q;
          end
`endif
        end else begin
          state_d = S_PLAY;
        end
      end
      S_DYING: begin
        if (cnt_q >= DEATH_CNT) begin
          if (lives_q == 2'd0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d      = S_PLAY;
            frog_reset_d = 1'b1;
          end
        end else begin
          state_d = S_DYING;
        end
      end
      S_LEVEL_UP: begin
        if (cnt_q >= LEVELUP_CNT) begin
          state_d      = S_PLAY;
          frog_reset_d = 1'b1;
        end else begin
          state_d = S_LEVEL_UP;
        end
      end
      S_GAME_OVER: begin
        // Level stays on display until a restart is accepted.
        if ((cnt_q >= OVER_CNT) && start_edge_s) begin
          state_d      = S_PLAY;
          level_d      = 7'd0;
          lives_d      = START_LIVES_C;
          frog_reset_d = 1'b1;
        end else begin
          state_d = S_GAME_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (i_Frame_Tick && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_d == S_DYING) || (state_d == S_GAME_OVER)) begin
      flash_d = cnt_d[3];
    end else begin
      flash_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      level_q      <= 7'd0;
      lives_q      <= START_LIVES_C;
      lives_led_q  <= lives_therm(START_LIVES_C);
      cnt_q        <= 8'd0;
      frog_reset_q <= 1'b0;
      flash_q      <= 1'b0;
      start_hist_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      lives_led_q  <= lives_therm(lives_d);
      cnt_q        <= cnt_d;
      frog_reset_q <= frog_reset_d;
      flash_q      <= flash_d;
      start_hist_q <= i_Game_Start;
    end
  end

  assign o_State      = state_q;
  assign o_Level      = level_q;
  assign o_Lives      = lives_q;
  assign o_Lives_LED  = lives_led_q;
  assign o_Frog_Reset = frog_reset_q;
  assign o_Cars_En    = (state_q == S_PLAY);
  assign o_Flash      = flash_q;

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Self-checking bench for frogger_round_ctrl: directed scenarios plus randomized run against a behavioural game model.
module tb_frogger_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, tick, coll;
  logic [4:0] fy;
  logic [2:0] o_State;
  logic [6:0] o_Level;
  logic [1:0] o_Lives;
  logic [2:0] o_Lives_LED;
  logic       o_Frog_Reset, o_Cars_En, o_Flash;

  int checks = 0;
  int errors = 0;

  // Behavioural game model: phase number, level, lives, frames counted in phase.
  int m_phase = 0;
  int m_level = 0;
  int m_lives = 3;
  int m_frames = 0;
  int m_prev_btn = 1;
  int m_respawn = 0;

  frogger_round_ctrl dut (
    .i_Clk(clk), .i_Rst(rst), .i_Game_Start(start), .i_Frame_Tick(tick),
    .i_Collided(coll), .i_Frog_Y(fy), .o_State(o_State), .o_Level(o_Level),
    .o_Lives(o_Lives), .o_Lives_LED(o_Lives_LED), .o_Frog_Reset(o_Frog_Reset),
    .o_Cars_En(o_Cars_En), .o_Flash(o_Flash)
  );

  always #20 clk = ~clk;

  task automatic model_step(input int r, input int b, input int t, input int c, input int y);
    int pressed;
    int nxt;
    if (r != 0) begin
      m_phase = 0; m_level = 0; m_lives = 3; m_frames = 0; m_prev_btn = 1; m_respawn = 0;
      return;
    end
    pressed = (b != 0 && m_prev_btn == 0) ? 1 : 0;
    m_prev_btn = b;
    nxt = m_phase;
    m_respawn = 0;
    if (m_phase == 0 && pressed == 1) begin
      nxt = 1; m_level = 0; m_lives = 3; m_respawn = 1;
    end else if (m_phase == 1 && c != 0) begin
      nxt = 2; m_lives = m_lives - 1;
    end else if (m_phase == 1 && y == 0) begin
      nxt = 3;
      m_level = (m_level + 1 > 99) ? 99 : m_level + 1;
`ifdef FROGGER_BONUS_LIFE_EN
      if (m_level % 5 == 0 && m_lives < 3) m_lives = m_lives + 1;
`endif
    end else if (m_phase == 2 && m_frames >= 60) begin
      if (m_lives == 0) nxt = 4;
      else begin nxt = 1; m_respawn = 1; end
    end else if (m_phase == 3 && m_frames >= 30) begin
      nxt = 1; m_respawn = 1;
    end else if (m_phase == 4 && m_frames >= 180 && pressed == 1) begin
      nxt = 1; m_level = 0; m_lives = 3; m_respawn = 1;
    end
    if (nxt != m_phase) m_frames = 0;
    else if (t != 0 && m_frames < 255) m_frames = m_frames + 1;
    m_phase = nxt;
  endtask

  task automatic cycle(input logic r, input logic b, input logic t, input logic c, input logic [4:0] y);
    rst = r; start = b; tick = t; coll = c; fy = y;
    model_step(int'(r), int'(b), int'(t), int'(c), int'(y));
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd5);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd5);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", o_State); end
    checks++; if (o_Lives !== 2'd3 || o_Level !== 7'd0) begin errors++; $display("FAIL reset_vals lives %0d level %0d want 3 0", o_Lives, o_Level); end
    checks++; if (o_Lives_LED !== 3'b111 || o_Cars_En !== 1'b0 || o_Flash !== 1'b0 || o_Frog_Reset !== 1'b0) begin
      errors++; $display("FAIL reset_outs led %b cars %b flash %b frst %b want 111 0 0 0", o_Lives_LED, o_Cars_En, o_Flash, o_Frog_Reset); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1 || o_Cars_En !== 1'b1) begin
      errors++; $display("FAIL start_play state %0d frst %b cars %b want 1 1 1", o_State, o_Frog_Reset, o_Cars_En); end
    checks++; if (o_Lives !== 2'd3 || o_Level !== 7'd0) begin errors++; $display("FAIL start_vals lives %0d level %0d want 3 0", o_Lives, o_Level); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    checks++; if (o_Frog_Reset !== 1'b0 || o_State !== 3'd1) begin errors++; $display("FAIL start_pulse frst %b state %0d want 0 1", o_Frog_Reset, o_State); end
  endtask

  task automatic test_collide_goal;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    checks++; if (o_State !== 3'd2 || o_Lives !== 2'd2 || o_Level !== 7'd0 || o_Cars_En !== 1'b0) begin
      errors++; $display("FAIL collide_prio state %0d lives %0d level %0d cars %b want 2 2 0 0", o_State, o_Lives, o_Level, o_Cars_En); end
    checks++; if (o_Lives_LED !== 3'b011) begin errors++; $display("FAIL lives_led got %b want 011", o_Lives_LED); end
    ticks(60);
    checks++; if (o_State !== 3'd2) begin errors++; $display("FAIL dying_boundary state %0d want 2", o_State); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1) begin errors++; $display("FAIL dying_exit state %0d frst %b want 1 1", o_State, o_Frog_Reset); end
  endtask

  task automatic test_levelup;
    for (int g = 1; g <= 100; g++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      checks++; if (o_State !== 3'd3 || o_Level !== 7'((g > 99) ? 99 : g)) begin
        errors++; $display("FAIL levelup_entry goal %0d state %0d level %0d want 3 %0d", g, o_State, o_Level, (g > 99) ? 99 : g); end
      ticks(30);
      if (g == 1) begin
        checks++; if (o_State !== 3'd3) begin errors++; $display("FAIL levelup_boundary state %0d want 3", o_State); end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
      checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1) begin errors++; $display("FAIL levelup_exit goal %0d state %0d frst %b want 1 1", g, o_State, o_Frog_Reset); end
    end
  endtask

  task automatic test_flash_and_reset;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
      checks++; if (o_Flash !== 1'(((k / 8) % 2)) || o_State !== 3'd2) begin
        errors++; $display("FAIL flash tick %0d flash %b state %0d want %0d 2", k, o_Flash, o_State, (k / 8) % 2); end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd0 || o_Level !== 7'd0 || o_Lives !== 2'd3 || o_Frog_Reset !== 1'b0 || o_Flash !== 1'b0 || o_Cars_En !== 1'b0) begin
      errors++; $display("FAIL mid_reset state %0d level %0d lives %0d frst %b flash %b cars %b", o_State, o_Level, o_Lives, o_Frog_Reset, o_Flash, o_Cars_En); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd0 || o_Frog_Reset !== 1'b0) begin errors++; $display("FAIL post_reset state %0d frst %b want 0 0", o_State, o_Frog_Reset); end
  endtask

  task automatic test_game_over;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    ticks(30);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    for (int n = 1; n <= 3; n++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
      checks++; if (o_Lives !== 2'(3 - n)) begin errors++; $display("FAIL lives_dec n %0d got %0d want %0d", n, o_Lives, 3 - n); end
      ticks(60);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    end
    checks++; if (o_State !== 3'd4 || o_Level !== 7'd1) begin errors++; $display("FAIL game_over state %0d level %0d want 4 1", o_State, o_Level); end
    ticks(99);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd4) begin errors++; $display("FAIL early_restart state %0d want 4", o_State); end
    ticks(85);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
    checks++; if (o_State !== 3'd1 || o_Lives !== 2'd3 || o_Level !== 7'd0 || o_Frog_Reset !== 1'b1) begin
      errors++; $display("FAIL restart state %0d lives %0d level %0d frst %b want 1 3 0 1", o_State, o_Lives, o_Level, o_Frog_Reset); end
  endtask

`ifdef FROGGER_BONUS_LIFE_EN
  task automatic test_bonus;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    ticks(60);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    for (int g = 1; g <= 10; g++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      checks++; if (o_Lives !== ((g < 5) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL bonus level %0d lives %0d", g, o_Lives); end
      ticks(30);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    end
  endtask
`endif

  task automatic test_random;
    logic b;
    b = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) b = ~b;
      cycle(($urandom_range(0, 2999) == 0) ? 1'b1 : 1'b0, b, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 5'($urandom_range(0, 23)));
      checks++;
      if (o_State !== 3'(m_phase) || o_Level !== 7'(m_level) || o_Lives !== 2'(m_lives) ||
          o_Lives_LED !== 3'((1 << m_lives) - 1) || o_Frog_Reset !== 1'(m_respawn) ||
          o_Cars_En !== (m_phase == 1) || o_Flash !== ((m_phase == 2 || m_phase == 4) && ((m_frames / 8) % 2 == 1))) begin
        errors++;
        $display("FAIL random cyc %0d got st %0d lv %0d li %0d led %b fr %b ce %b fl %b want st %0d lv %0d li %0d fr %0d frames %0d",
                 i, o_State, o_Level, o_Lives, o_Lives_LED, o_Frog_Reset, o_Cars_En, o_Flash, m_phase, m_level, m_lives, m_respawn, m_frames);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; coll = 1'b0; fy = 5'd5;
    test_reset;
    test_collide_goal;
    test_levelup;
    test_flash_and_reset;
    test_game_over;
`ifdef FROGGER_BONUS_LIFE_EN
    test_bonus;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
